ct_f_spsram_lane_wrap: RTL and testbench
========================================

Name: ct_f_spsram_lane_wrap

Overview:
Generic FPGA single-port SRAM wrapper for the C910 FPGA build. It is built from NUM_LANES fpga_ram instances, each LANE_WIDTH wide, and replaces the fixed-geometry per-size wrappers. Over the fixed wrappers it adds:
- a post-reset init engine that sweeps every word to INIT_VALUE,
- a Q hold register, so Q only changes after a read access,
- an optional output pipeline stage.

Parameters:
- ADDR_WIDTH, 13: address bits. DEPTH = 2**ADDR_WIDTH words.
- LANE_WIDTH, 8: bits per lane, i.e. per fpga_ram instance.
- NUM_LANES, 4: lane count. DATA_WIDTH = NUM_LANES*LANE_WIDTH, held as a derived localparam.
- OUT_REG, 0: 0 gives read latency 1; 1 adds a Q register, giving read latency 2.
- INIT_EN, 1: 1 runs the clear sweep after reset; 0 makes the block ready immediately after reset.
- INIT_VALUE, 0: DATA_WIDTH-bit value written to every word during the sweep.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset. Synchronous, active-high. Single clock domain.
- A  in  ADDR_WIDTH  access address.
- CEN  in  1  chip enable, active low.
- D  in  DATA_WIDTH  write data.
- GWEN  in  1  global write enable, active low. 0 = write, 1 = read.
- WEN  in  DATA_WIDTH  bit write-enable mask, active low. Lane k is enabled by bit (k+1)*LANE_WIDTH-1 only.
- Q  out  DATA_WIDTH  read data.
- INIT_DONE  out  1  1 = sweep complete and the block accepts accesses.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Q=0, INIT_DONE=0, hold/pipeline registers=0, held address=0, read-pending flag=0.
  - State becomes INIT if INIT_EN=1, otherwise READY. Init counter=0.
- RST asserted mid-sweep or mid-access restarts from the reset state. The partial sweep is abandoned. RAM contents are not preserved as cleared.
- FSM states are INIT and READY.
  - INIT: each cycle, write INIT_VALUE to all lanes at address cnt, then cnt++. External A/CEN/D/GWEN/WEN are ignored entirely. After writing cnt=DEPTH-1, go to READY.
  - The sweep takes exactly DEPTH cycles. INIT_DONE=1 from the cycle after the last sweep write.
  - READY: normal SRAM operation. INIT_DONE stays 1 until the next RST.
- Access is valid only when INIT_DONE=1 and CEN=0.
  - Write: GWEN=0. Lane k is written iff its WEN bit is 0. The data is D[k*LANE_WIDTH +: LANE_WIDTH].
  - Read: GWEN=1. All lanes are read.
  - GWEN=0 with all lane bits of WEN at 1 is a no-op write. It does not affect Q.
- Address: when CEN=0, A is registered as the held address. When CEN=1, the RAM is driven with the held address, so RAM output is stable.
- Read path:
  - A read at edge N sets rd_pend for cycle N+1.
  - While rd_pend=1, the internal rdata = RAM output. rdata also loads the hold register at edge N+1.
  - Otherwise rdata = hold register.
  - OUT_REG=0: Q = rdata. Valid in the cycle after the read edge.
  - OUT_REG=1: Q = rdata registered, one cycle later.
- Write cycles, idle cycles (CEN=1), and INIT cycles never change the hold register. Q retains the last read value, or 0 if there has been no read since reset.
- Back-to-back reads at consecutive addresses give one result per cycle with no bubbles.
- Read after write to the same address in the next cycle returns the new data, for written lanes only.
- Address wrap: the sweep counter is ADDR_WIDTH+1 bits wide and the terminal count compare is done on DEPTH-1. There is no wrap into a second pass.
- No combinational path from inputs to Q except through rd_pend/RAM. Q is glitch-free to outputs.

Test Plan:
1. ADDR_WIDTH=4, INIT_EN=1, INIT_VALUE=32'hA5A5A5A5, RST for 1 cycle:
   - INIT_DONE rises exactly 16 cycles after RST deasserts.
   - Reads of all 16 addresses return A5A5A5A5.
   - A write issued during INIT to addr 3 with D=0 is ignored; addr 3 still reads A5A5A5A5.
2. Write addr 5 D=32'h11223344, WEN all 0; then write addr 5 D=32'hFFFFFFFF with only WEN[15]=0; then read 5:
   - Q=32'h1122FF44 one cycle after the read (OUT_REG=0), or two cycles after (OUT_REG=1).
3. Read addr 5 then hold CEN=1 for 10 cycles, then write addr 6:
   - Q stays 32'h1122FF44 throughout the idle and write cycles.
   - Q changes only after a following read of addr 6.
4. Back-to-back reads of addrs 0,1,2,3 previously written with 0,1,2,3:
   - Q sequence is 0,1,2,3 on consecutive cycles, starting at latency 1 or 2 per OUT_REG.
5. Assert RST at sweep cycle 7 of 16:
   - INIT_DONE=0 and Q=0 immediately.
   - The sweep restarts; INIT_DONE rises 16 cycles after RST drops.
6. INIT_EN=0:
   - INIT_DONE=1 on the first cycle after RST.
   - Write then read addr 0 with 32'hDEADBEEF returns DEADBEEF.
   - Sweep with NUM_LANES=2, LANE_WIDTH=16 and NUM_LANES=8, LANE_WIDTH=9, checking lane masking per WEN MSB-of-lane.

Source files
------------

// File: rtl/ct_f_spsram_lane_wrap.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_lane_wrap
//   Single-port SRAM wrapper built from NUM_LANES fpga_ram lanes of
//   LANE_WIDTH bits each. After reset an optional sweep writes INIT_VALUE to
//   every word. Q is taken from a hold register, so it changes only after a
//   read. OUT_REG=1 adds one more register stage on Q.
//
// Ports
//   CLK        clock
//   RST        synchronous active-high reset
//   A          access address
//   CEN        chip enable, active low
//   D          write data
//   GWEN       global write enable, active low (0 = write, 1 = read)
//   WEN        per-bit write mask, active low; lane k uses only its MSB
//   Q          read data
//   INIT_DONE  sweep finished, accesses accepted
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_INIT  | clear sweep: write INIT_VALUE at cnt_q, external ports ignored
//   ST_READY | normal SRAM operation
// ----------------------------------------------------------------------------

module fpga_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
    dout_q <= mem_q[addr_i];
  end

  assign dout_o = dout_q;

endmodule

module ct_f_spsram_lane_wrap #(
  parameter int ADDR_WIDTH = 13,
  parameter int LANE_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int OUT_REG    = 0,
  parameter int INIT_EN    = 1,
  localparam int DATA_WIDTH = NUM_LANES * LANE_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_DONE
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic                  acc;
  logic                  rd_acc;
  logic [NUM_LANES-1:0]  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rdata;

  // Only the lane MSBs of WEN carry meaning; the rest is folded away here.
  logic                  unused_wen;
  assign unused_wen = ^WEN;

  // init_done_q is only set in ST_READY, so it alone qualifies accesses.
  assign acc    = init_done_q & ~CEN;
  assign rd_acc = acc & GWEN;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    ram_we      = '0;
    // Idle cycles replay the held address so the RAM output stays put.
    ram_addr    = addr_q;
    ram_wdata   = D;
    case (state_q)
      ST_INIT: begin
        ram_we    = '1;
        ram_addr  = cnt_q[ADDR_WIDTH-1:0];
        ram_wdata = INIT_VALUE;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        init_done_d = 1'b1;
        if (acc) begin
          ram_addr = A;
          if (!GWEN) begin
            for (int k = 0; k < NUM_LANES; k++) begin
              ram_we[k] = ~WEN[(k+1)*LANE_WIDTH-1];
            end
          end
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_acc;
      if (acc) begin
        addr_q <= A;
      end
      if (rd_pend_q) begin
        hold_q <= ram_rdata;
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    fpga_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (LANE_WIDTH)
    ) u_ram (
      .clk_i  (CLK),
      .we_i   (ram_we[k]),
      .addr_i (ram_addr),
      .din_i  (ram_wdata[k*LANE_WIDTH +: LANE_WIDTH]),
      .dout_o (ram_rdata[k*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  // RAM output is fresh only in the cycle right after a read.
  assign rdata = rd_pend_q ? ram_rdata : hold_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_pipe_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        q_pipe_q <= '0;
      end else begin
        q_pipe_q <= rdata;
      end
    end
    assign Q = q_pipe_q;
  end else begin : g_no_out_reg
    assign Q = rdata;
  end

  assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_ct_f_spsram_lane_wrap.sv
module tb_ct_f_spsram_lane_wrap;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT0: 4 x 8, latency 1, sweep to A5A5A5A5
  logic        rst0, cen0, gwen0, done0;
  logic [3:0]  a0;
  logic [31:0] d0, wen0, q0;

  // DUT1: 2 x 16, latency 2, no sweep
  logic        rst1, cen1, gwen1, done1;
  logic [3:0]  a1;
  logic [31:0] d1, wen1, q1;

  // DUT2: 8 x 9, latency 1, sweep to 0
  logic        rst2, cen2, gwen2, done2;
  logic [3:0]  a2;
  logic [71:0] d2, wen2, q2;

  ct_f_spsram_lane_wrap #(
    .ADDR_WIDTH(4), .LANE_WIDTH(8), .NUM_LANES(4), .OUT_REG(0), .INIT_EN(1),
    .INIT_VALUE(32'hA5A5A5A5)
  ) u_dut0 (
    .CLK(clk), .RST(rst0), .A(a0), .CEN(cen0), .D(d0), .GWEN(gwen0),
    .WEN(wen0), .Q(q0), .INIT_DONE(done0)
  );

  ct_f_spsram_lane_wrap #(
    .ADDR_WIDTH(4), .LANE_WIDTH(16), .NUM_LANES(2), .OUT_REG(1), .INIT_EN(0),
    .INIT_VALUE(32'h0)
  ) u_dut1 (
    .CLK(clk), .RST(rst1), .A(a1), .CEN(cen1), .D(d1), .GWEN(gwen1),
    .WEN(wen1), .Q(q1), .INIT_DONE(done1)
  );

  ct_f_spsram_lane_wrap #(
    .ADDR_WIDTH(4), .LANE_WIDTH(9), .NUM_LANES(8), .OUT_REG(0), .INIT_EN(1),
    .INIT_VALUE(72'h0)
  ) u_dut2 (
    .CLK(clk), .RST(rst2), .A(a2), .CEN(cen2), .D(d2), .GWEN(gwen2),
    .WEN(wen2), .Q(q2), .INIT_DONE(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc0(input logic cen, input logic gwen, input logic [3:0] a,
                      input logic [31:0] d, input logic [31:0] wen);
    cen0 = cen; gwen0 = gwen; a0 = a; d0 = d; wen0 = wen;
    tick();
  endtask

  task automatic acc1(input logic cen, input logic gwen, input logic [3:0] a,
                      input logic [31:0] d, input logic [31:0] wen);
    cen1 = cen; gwen1 = gwen; a1 = a; d1 = d; wen1 = wen;
    tick();
  endtask

  task automatic acc2(input logic cen, input logic gwen, input logic [3:0] a,
                      input logic [71:0] d, input logic [71:0] wen);
    cen2 = cen; gwen2 = gwen; a2 = a; d2 = d; wen2 = wen;
    tick();
  endtask

  initial begin
    logic [71:0] wmask2;

    rst0 = 1'b1; cen0 = 1'b1; gwen0 = 1'b1; a0 = '0; d0 = '0; wen0 = '1;
    rst1 = 1'b1; cen1 = 1'b1; gwen1 = 1'b1; a1 = '0; d1 = '0; wen1 = '1;
    rst2 = 1'b1; cen2 = 1'b1; gwen2 = 1'b1; a2 = '0; d2 = '0; wen2 = '1;
    tick();
    tick();

    chk("rst_q0", q0, 72'h0);
    chk("rst_done0", done0, 72'h0);
    chk("rst_q1", q1, 72'h0);
    chk("rst_done1", done1, 72'h0);
    chk("rst_done2", done2, 72'h0);

    // ---- DUT0 sweep: 16 cycles, writes during the sweep are ignored ----
    rst0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("sweep_busy", done0, 72'h0);
      if (i < 6) acc0(1'b0, 1'b0, 4'd3, 32'h0, 32'h0);
      else       acc0(1'b1, 1'b1, 4'd0, 32'h0, '1);
    end
    chk("sweep_done", done0, 72'h1);

    for (int i = 0; i < 16; i++) begin
      acc0(1'b0, 1'b1, 4'(i), 32'h0, '1);
      chk("sweep_read", q0, 72'hA5A5A5A5);
    end

    // ---- lane masking on lane 1 via WEN[15] only ----
    acc0(1'b0, 1'b0, 4'd5, 32'h11223344, 32'h0);
    chk("write_keeps_q", q0, 72'hA5A5A5A5);
    acc0(1'b0, 1'b0, 4'd5, 32'hFFFFFFFF, 32'hFFFF7FFF);
    acc0(1'b0, 1'b1, 4'd5, 32'h0, '1);
    chk("mask_read5", q0, 72'h1122FF44);

    // ---- hold across idle, write, no-op write ----
    for (int i = 0; i < 10; i++) begin
      acc0(1'b1, 1'b1, 4'(i), 32'h0, '1);
      chk("idle_hold", q0, 72'h1122FF44);
    end
    acc0(1'b0, 1'b0, 4'd6, 32'hCAFEF00D, 32'h0);
    chk("write6_hold", q0, 72'h1122FF44);
    acc0(1'b0, 1'b0, 4'd6, 32'h0, 32'hFFFFFFFF);
    chk("noop_hold", q0, 72'h1122FF44);
    acc0(1'b0, 1'b1, 4'd6, 32'h0, '1);
    chk("read6", q0, 72'hCAFEF00D);
    acc0(1'b1, 1'b1, 4'd9, 32'h0, '1);
    chk("idle_addr_change", q0, 72'hCAFEF00D);

    // ---- back-to-back reads ----
    for (int i = 0; i < 4; i++) acc0(1'b0, 1'b0, 4'(i), 32'(i), 32'h0);
    for (int i = 0; i < 4; i++) begin
      acc0(1'b0, 1'b1, 4'(i), 32'h0, '1);
      chk("b2b_read", q0, 72'(i));
    end

    // ---- read directly after write to same address ----
    acc0(1'b0, 1'b0, 4'd7, 32'h12345678, 32'h0);
    acc0(1'b0, 1'b1, 4'd7, 32'h0, '1);
    chk("raw7", q0, 72'h12345678);

    // ---- reset clears Q; reset mid-sweep restarts the sweep ----
    rst0 = 1'b1;
    acc0(1'b1, 1'b1, 4'd0, 32'h0, '1);
    chk("rst2_q0", q0, 72'h0);
    chk("rst2_done0", done0, 72'h0);
    rst0 = 1'b0;
    repeat (7) acc0(1'b1, 1'b1, 4'd0, 32'h0, '1);
    chk("mid_sweep_busy", done0, 72'h0);
    rst0 = 1'b1;
    acc0(1'b1, 1'b1, 4'd0, 32'h0, '1);
    chk("mid_rst_done0", done0, 72'h0);
    chk("mid_rst_q0", q0, 72'h0);
    rst0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("resweep_busy", done0, 72'h0);
      acc0(1'b1, 1'b1, 4'd0, 32'h0, '1);
    end
    chk("resweep_done", done0, 72'h1);
    acc0(1'b0, 1'b1, 4'd5, 32'h0, '1);
    chk("resweep_read5", q0, 72'hA5A5A5A5);
    acc0(1'b0, 1'b1, 4'd7, 32'h0, '1);
    chk("resweep_read7", q0, 72'hA5A5A5A5);

    // ---- DUT1: no sweep, latency 2, 16-bit lanes ----
    rst1 = 1'b0;
    acc1(1'b1, 1'b1, 4'd0, 32'h0, '1);
    chk("noinit_done", done1, 72'h1);
    acc1(1'b0, 1'b0, 4'd0, 32'hDEADBEEF, 32'h0);
    acc1(1'b0, 1'b1, 4'd0, 32'h0, '1);
    chk("lat2_early", q1, 72'h0);
    acc1(1'b1, 1'b1, 4'd0, 32'h0, '1);
    chk("lat2_read0", q1, 72'hDEADBEEF);
    acc1(1'b0, 1'b0, 4'd1, 32'h12345678, 32'h0);
    acc1(1'b0, 1'b0, 4'd1, 32'hAAAABBBB, 32'h7FFF8000);
    acc1(1'b0, 1'b1, 4'd1, 32'h0, '1);
    chk("lat2_b2b_0", q1, 72'hDEADBEEF);
    acc1(1'b0, 1'b1, 4'd0, 32'h0, '1);
    chk("lat2_b2b_1", q1, 72'hAAAA5678);
    acc1(1'b1, 1'b1, 4'd0, 32'h0, '1);
    chk("lat2_b2b_2", q1, 72'hDEADBEEF);

    // ---- DUT2: 8 x 9 lanes, only lane MSB of WEN matters ----
    rst2 = 1'b0;
    for (int i = 0; i < 16; i++) acc2(1'b1, 1'b1, 4'd0, 72'h0, '1);
    chk("w9_done", done2, 72'h1);
    acc2(1'b0, 1'b0, 4'd2, '1, 72'h0);
    wmask2 = '1;
    wmask2[35] = 1'b0;
    wmask2[52:45] = '0;
    acc2(1'b0, 1'b0, 4'd2, 72'h0, wmask2);
    acc2(1'b0, 1'b1, 4'd2, 72'h0, '1);
    chk("w9_mask", q2, 72'hFF_FFFF_FFF0_07FF_FFFF);
    acc2(1'b0, 1'b1, 4'd9, 72'h0, '1);
    chk("w9_swept", q2, 72'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
